// File: rtl/fifo_rr_drain_pkg.sv
// Shared state type and round-robin search helper for the fifo_rr_drain scheduler.
package fifo_rr_drain_pkg;

    localparam int RR_MAX_CH = 16;
    localparam int RR_IDX_W  = 4;

    typedef enum logic {IDLE, DRAIN} drain_state_t;

    // Searches last+1, last+2, ... modulo n; returns last unchanged when nothing requests.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX_CH-1:0] req,
        input logic [RR_IDX_W-1:0]  last,
        input int unsigned          n
    );
        logic [RR_IDX_W-1:0] pick;
        logic                hit;
        logic [31:0]         cand;
        pick = last;
        hit  = 1'b0;
        cand = '0;
        for (int unsigned i = 1; i <= RR_MAX_CH; i++) begin
            cand = (32'(last) + 32'(i)) % 32'(n);
            if (!hit && (i <= n) && req[cand[RR_IDX_W-1:0]]) begin
                pick = cand[RR_IDX_W-1:0];
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// Combinational rotating priority encoder: first requester after 'last', wrapping.
module rr_pick
    import fifo_rr_drain_pkg::*;
#(
    parameter  int CH_NUM = 4,
    localparam int CH_W   = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    logic [RR_MAX_CH-1:0] req_ext;
    logic [RR_IDX_W-1:0]  pick;

    always_comb begin
        req_ext             = '0;
        req_ext[CH_NUM-1:0] = req;
        pick                = rr_next(req_ext, RR_IDX_W'(last), CH_NUM);
        found               = |req;
        idx                 = CH_W'(pick);
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of CH_NUM FWFT read ports into one registered valid/ready stream,
// granting one channel at a time for bursts of up to BURST_MAX words.
module fifo_rr_drain
    import fifo_rr_drain_pkg::*;
#(
    parameter  int CH_NUM    = 4,
    parameter  int DATA_W    = 16,
    parameter  int BURST_MAX = 4,
    localparam int CH_W      = $clog2(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     anrst,
    input  logic                     ena,
    input  logic [CH_NUM-1:0]        in_empty,
    input  logic [CH_NUM*DATA_W-1:0] in_r_data,
    output logic [CH_NUM-1:0]        in_r_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy
);

    localparam int              CNT_W     = 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [CH_W-1:0]  TOP_CH    = CH_W'(CH_NUM - 1);

    drain_state_t       state, state_nx;
    logic [CH_W-1:0]    cur_ch, cur_ch_nx;
    logic [CH_W-1:0]    last_ch, last_ch_nx;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nx;
    logic               can_load, pop;
    logic               pick_found;
    logic [CH_W-1:0]    pick_idx;
    logic [DATA_W-1:0]  head;

    rr_pick #(.CH_NUM(CH_NUM)) u_pick (
        .req   (~in_empty),
        .last  (last_ch),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // in_empty is sampled before the pop, so a FIFO emptied by a pop is seen one cycle later.
    always_comb begin
        can_load         = ~out_valid | out_ready;
        head             = in_r_data[cur_ch*DATA_W +: DATA_W];
        pop              = (state == DRAIN) & ena & ~in_empty[cur_ch] & can_load;
        in_r_req         = '0;
        in_r_req[cur_ch] = pop;
        busy             = (state == DRAIN) | out_valid;

        state_nx     = state;
        cur_ch_nx    = cur_ch;
        last_ch_nx   = last_ch;
        burst_cnt_nx = burst_cnt;

        case (state)
            IDLE: begin
                if (ena && pick_found) begin
                    cur_ch_nx    = pick_idx;
                    last_ch_nx   = pick_idx;
                    burst_cnt_nx = '0;
                    state_nx     = DRAIN;
                end
            end
            DRAIN: begin
                if (!ena || in_empty[cur_ch]) begin
                    state_nx = IDLE;
                end else if (pop) begin
                    burst_cnt_nx = burst_cnt + 1'b1;
                    if (burst_cnt == LAST_BEAT) begin
                        state_nx = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state     <= IDLE;
            cur_ch    <= '0;
            last_ch   <= TOP_CH;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            cur_ch    <= cur_ch_nx;
            last_ch   <= last_ch_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

    // Output register: a new word loads only when the slot is empty or being consumed.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= head;
            out_ch    <= cur_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Randomised and directed bench for fifo_rr_drain with FIFO models and per-channel scoreboards.
module tb_fifo_rr_drain;

    localparam int CH_NUM    = 4;
    localparam int DATA_W    = 16;
    localparam int BURST_MAX = 4;
    localparam int CH_W      = $clog2(CH_NUM);

    logic                     clk;
    logic                     anrst;
    logic                     ena;
    logic [CH_NUM-1:0]        in_empty;
    logic [CH_NUM*DATA_W-1:0] in_r_data;
    logic [CH_NUM-1:0]        in_r_req;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     busy;

    fifo_rr_drain #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .anrst     (anrst),
        .ena       (ena),
        .in_empty  (in_empty),
        .in_r_data (in_r_data),
        .in_r_req  (in_r_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    logic [DATA_W-1:0] fifo_q [CH_NUM][$];
    logic [DATA_W-1:0] exp_q  [CH_NUM][$];
    logic [DATA_W-1:0] acc_data [$];
    int                acc_ch   [$];
    int                acc_cyc  [$];
    logic [CH_NUM-1:0] pop_log  [$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < CH_NUM; k++) s += exp_q[k].size();
        return s;
    endfunction

    task automatic driveFifos();
        for (int k = 0; k < CH_NUM; k++) begin
            in_empty[k] = (fifo_q[k].size() == 0);
            in_r_data[k*DATA_W +: DATA_W] = (fifo_q[k].size() != 0) ? fifo_q[k][0] : '0;
        end
    endtask

    task automatic pushWord(input int ch, input logic [DATA_W-1:0] d);
        fifo_q[ch].push_back(d);
        exp_q[ch].push_back(d);
    endtask

    // One clock: drive at negedge, sample pre-edge, apply pops and consume words just after the edge.
    task automatic applyStimulus(input logic e, input logic r);
        logic [CH_NUM-1:0] req;
        logic              took;
        logic [DATA_W-1:0] d;
        int                c;
        ena       = e;
        out_ready = r;
        driveFifos();
        #1;
        req  = in_r_req;
        took = out_valid & out_ready;
        d    = out_data;
        c    = int'(out_ch);
        checkOutput("req_onehot", ($countones(req) <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (out_valid) checkOutput("busy_valid", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        pop_log.push_back(req);
        for (int k = 0; k < CH_NUM; k++) begin
            if (req[k]) begin
                checkOutput("pop_nonempty", (fifo_q[k].size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (fifo_q[k].size() > 0) void'(fifo_q[k].pop_front());
            end
        end
        if (took) begin
            acc_data.push_back(d);
            acc_ch.push_back(c);
            acc_cyc.push_back(cyc);
            if (exp_q[c].size() == 0) checkOutput("sb_underflow", 32'd0, 32'd1);
            else checkOutput("sb_data", 32'(d), 32'(exp_q[c].pop_front()));
        end
        driveFifos();
        @(negedge clk);
    endtask

    task automatic doReset();
        if (out_valid) begin
            if (exp_q[out_ch].size() > 0) void'(exp_q[out_ch].pop_front());
        end
        anrst = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data",  32'(out_data),  32'd0);
        checkOutput("rst_ch",    32'(out_ch),    32'd0);
        checkOutput("rst_req",   32'(in_r_req),  32'd0);
        checkOutput("rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        anrst = 1'b1;
    endtask

    task automatic drainAll(input int bound);
        int n = 0;
        while (pending() != 0 && n < bound) begin
            applyStimulus(1'b1, 1'b1);
            n++;
        end
        checkOutput("drain_left", 32'(pending()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, pbase, low;
        int ready_seq [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        int pop4_exp  [12] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0};
        int pop5_exp  [13] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0};
        int ch5_exp   [7]  = '{2, 2, 3, 3, 3, 3, 3};

        anrst     = 1'b0;
        ena       = 1'b0;
        out_ready = 1'b1;
        driveFifos();
        repeat (2) @(negedge clk);
        checkOutput("init_valid", 32'(out_valid), 32'd0);
        checkOutput("init_busy",  32'(busy),      32'd0);
        anrst = 1'b1;

        $display("[TB] idle with all channels empty");
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("idle_valid", 32'(out_valid), 32'd0);
            checkOutput("idle_req",   32'(in_r_req),  32'd0);
            checkOutput("idle_busy",  32'(busy),      32'd0);
        end

        $display("[TB] single channel, ten words");
        base = acc_data.size();
        for (int i = 0; i < 10; i++) pushWord(0, 16'(i));
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("t2_count", 32'(acc_data.size() - base), 32'd10);
        for (int i = 0; i < 10 && base + i < acc_data.size(); i++) begin
            checkOutput("t2_data", 32'(acc_data[base+i]), 32'(i));
            checkOutput("t2_ch",   32'(acc_ch[base+i]),   32'd0);
            if (i > 0)
                checkOutput("t2_gap", 32'(acc_cyc[base+i] - acc_cyc[base+i-1]),
                            (i % BURST_MAX == 0) ? 32'd2 : 32'd1);
        end
        drainAll(50);

        $display("[TB] four channels, eight words each");
        doReset();
        base = acc_data.size();
        for (int c = 0; c < CH_NUM; c++)
            for (int n = 0; n < 8; n++) pushWord(c, 16'(32'hC000 + c*256 + n));
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("t3_count", 32'(acc_data.size() - base), 32'd32);
        for (int i = 0; i < 32 && base + i < acc_data.size(); i++) begin
            int w, c, n;
            w = i % 16;
            c = w / 4;
            n = (i / 16) * 4 + (w % 4);
            checkOutput("t3_ch",   32'(acc_ch[base+i]),   32'(c));
            checkOutput("t3_data", 32'(acc_data[base+i]), 32'(32'hC000 + c*256 + n));
        end
        drainAll(50);

        $display("[TB] backpressure stall mid-burst");
        doReset();
        pbase = pop_log.size();
        for (int i = 0; i < 6; i++) pushWord(1, 16'(32'hA100 + i));
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, ready_seq[i] != 0);
            if (i >= 2 && i <= 4) begin
                checkOutput("t4_hold_data",  32'(out_data),  32'hA101);
                checkOutput("t4_hold_valid", 32'(out_valid), 32'd1);
            end
        end
        for (int i = 0; i < 12; i++)
            checkOutput("t4_pop", (pop_log[pbase+i] != 0) ? 32'd1 : 32'd0, 32'(pop4_exp[i]));
        drainAll(50);

        $display("[TB] early burst end then switch");
        doReset();
        pbase = pop_log.size();
        base  = acc_data.size();
        for (int i = 0; i < 2; i++) pushWord(2, 16'(32'hB200 + i));
        for (int i = 0; i < 5; i++) pushWord(3, 16'(32'hB300 + i));
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 13; i++)
            checkOutput("t5_pop", (pop_log[pbase+i] != 0) ? 32'd1 : 32'd0, 32'(pop5_exp[i]));
        checkOutput("t5_count", 32'(acc_data.size() - base), 32'd7);
        for (int i = 0; i < 7 && base + i < acc_data.size(); i++)
            checkOutput("t5_ch", 32'(acc_ch[base+i]), 32'(ch5_exp[i]));
        drainAll(50);

        $display("[TB] randomised traffic with a reset pulse");
        doReset();
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH_NUM; c++)
                if ($urandom_range(0, 99) < 25 && fifo_q[c].size() < 12)
                    pushWord(c, 16'($urandom));
            if (i == 300) begin
                doReset();
                pushWord(3, 16'($urandom));
                low = 0;
                while (fifo_q[low].size() == 0) low++;
                applyStimulus(1'b1, 1'b1);
                applyStimulus(1'b1, 1'b1);
                checkOutput("rst_first_grant", 32'(pop_log[pop_log.size()-1]), 32'(1 << low));
            end
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
        end
        drainAll(2000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
